mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum ACCESS cycles awaiting mem_ready before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-cache line request, held until i_ack.
REQ-005 i_we  input  1  1 = line writeback, 0 = line refill; stable while i_req.
REQ-006 i_addr  input  6  line address; stable while i_req.
REQ-007 i_wdata  input  64  writeback line data; stable while i_req.
REQ-008 i_rdata  output  64  registered refill data for I-side.
REQ-009 i_ack  output  1  one-cycle completion pulse to I-side.
REQ-010 d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  same directions, widths and meanings as the I-side ports, for the data cache.
REQ-011 mem_req  output  1  memory access strobe, held until mem_ready.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  6  memory line address.
REQ-014 mem_wdata  output  64  memory write line.
REQ-015 mem_rdata  input  64  memory read line, valid when mem_ready.
REQ-016 mem_ready  input  1  memory completion, sampled only in ACCESS.
REQ-017 err  output  1  one-cycle pulse, coincident with ack, on timeout abort.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; next state is a registered transition on each rising edge.
REQ-020 IDLE: if any req is high, latch the winner's we/addr/wdata into mem_* registers, record grant, and go to ACCESS; otherwise remain in IDLE.
REQ-021 Arbitration: with a single requester, it wins; with both requesting, the side not named by last_grant wins (round-robin).
REQ-022 ACCESS: mem_req=1 with the latched mem_we/mem_addr/mem_wdata held constant; the timeout counter increments each cycle.
REQ-023 ACCESS with mem_ready=1: for a read, capture mem_rdata into the granted side's rdata register; for a write, leave rdata unchanged; go to RESP.
REQ-024 ACCESS with mem_ready=0 and counter==TIMEOUT-1: set the abort flag, leave rdata unchanged, and go to RESP.
REQ-025 RESP: assert ack for the granted side only, assert err if aborted, set last_grant to the granted side, clear the counter, and go to IDLE.
REQ-026 mem_req, ack and err are driven from registered state only; mem_req is 0 in IDLE and RESP.
REQ-027 Minimum latency: req sampled at edge N gives ACCESS in cycle N+1; with mem_ready in that same cycle, ack appears in cycle N+2.
REQ-028 Requester protocol: the requester drops req at the edge after it sees ack; the arbiter re-evaluates req in IDLE only, so back-to-back grants are separated by one IDLE cycle.
REQ-029 A req change on the non-granted side during ACCESS/RESP has no effect on the transaction in flight.
REQ-030 A req deasserted by the granted side before ack is a protocol violation; the transaction still completes.
REQ-031 The losing requester waits at most one full transaction plus one IDLE cycle before being granted.

Reset
REQ-032 On reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, i_ack=0, d_ack=0, err=0, busy=0, counter=0, last_grant=I (so D wins the first tie).
REQ-033 Reset asserted mid-ACCESS or mid-RESP aborts the transaction: no ack or err is issued, and mem_req is 0 from the cycle after the reset edge.

Verification
REQ-034 I-side read, addr=6'h05, mem_ready in first ACCESS cycle with mem_rdata=64'hDEADBEEF_01234567 -> mem_addr=5, mem_we=0; i_rdata=64'hDEADBEEF_01234567; i_ack high 2 cycles after the req edge; d_ack=0.
REQ-035 d_req (write, addr=6'h2A, wdata=64'hA5A5...) and i_req (read, addr=6'h01) raised in the same cycle after reset -> D served first (mem_we=1, mem_addr=2A); I granted after one IDLE cycle.
REQ-036 Both sides requesting continuously for 4 transactions -> grant order D, I, D, I; each ack is a single-cycle pulse.
REQ-037 mem_ready held 0 with TIMEOUT=15 -> mem_req high exactly 15 cycles; ack+err pulse together; rdata keeps its prior value; busy=0 in the following cycle.
REQ-038 mem_ready delayed 3 cycles during an I-side read while d_req toggles -> mem_addr stable for 4 ACCESS cycles; only i_ack pulses.
REQ-039 Reset raised in the 2nd ACCESS cycle -> mem_req=0, busy=0 next cycle; no ack or err pulse; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter: round-robin I/D cache line arbiter onto a single memory  |
// | port, with per-access timeout abort.                  Revision: 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [5:0]  i_addr,
  input  logic [63:0] i_wdata,
  output logic [63:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [5:0]  d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_grant_d;
  logic        r_last_grant_d;
  logic        r_abort;
  logic [7:0]  r_cnt;
  logic        r_mem_we;
  logic [5:0]  r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic [63:0] r_i_rdata;
  logic [63:0] r_d_rdata;
  logic        w_req_any;
  logic        w_pick_d;
  logic        w_timeout;

  assign w_req_any = i_req | d_req;
  // D wins a tie only when I was served last.
  assign w_pick_d  = d_req & (~i_req | ~r_last_grant_d);
  assign w_timeout = ~mem_ready & (r_cnt == c_CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_next = S_ACCESS;
      S_ACCESS: if (mem_ready || w_timeout) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_grant_d      <= 1'b0;
      r_last_grant_d <= 1'b0;
      r_abort        <= 1'b0;
      r_cnt          <= 8'd0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 6'd0;
      r_mem_wdata    <= 64'd0;
      r_i_rdata      <= 64'd0;
      r_d_rdata      <= 64'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= 8'd0;
          r_abort <= 1'b0;
          if (w_req_any) begin
            r_grant_d   <= w_pick_d;
            r_mem_we    <= w_pick_d ? d_we    : i_we;
            r_mem_addr  <= w_pick_d ? d_addr  : i_addr;
            r_mem_wdata <= w_pick_d ? d_wdata : i_wdata;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_ready) begin
            if (!r_mem_we) begin
              if (r_grant_d) r_d_rdata <= mem_rdata;
              else           r_i_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_abort <= 1'b1;
          end
        end
        S_RESP: begin
          r_last_grant_d <= r_grant_d;
          r_cnt          <= 8'd0;
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  assign mem_req   = (r_state == S_ACCESS);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ack     = (r_state == S_RESP) & ~r_grant_d;
  assign d_ack     = (r_state == S_RESP) &  r_grant_d;
  assign err       = (r_state == S_RESP) &  r_abort;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
